// File: rtl/fir_decim_out.sv
// fir_decim_out: decimating output stage for the FIR filter.
// Sums DECIM consecutive filter samples, divides the sum by DECIM with an
// arithmetic shift, saturates the quotient to 8 bits and queues it in a
// small output FIFO with a valid/ready handshake.
// DECIM must be 2, 4 or 8. FIFO_DEPTH must be a power of two from 2 to 16,
// so the FIFO pointers wrap naturally at FIFO_DEPTH.
module fir_decim_out #(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [10:0] filter_in,
  input  logic              in_valid,
  input  logic              phase_clr,
  output logic signed [7:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              sat_flag,
  output logic              overflow
);

  localparam int SHIFT = $clog2(DECIM);
  localparam int CW    = SHIFT;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int OW    = PW + 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(DECIM - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

  // Decimation state
  logic signed [13:0] acc;
  logic [CW-1:0]      cnt;

  // Datapath for the result of the current group
  logic signed [13:0] sum;
  logic signed [13:0] shifted;
  logic signed [7:0]  result;
  logic               clipped;

  // Control
  logic last;
  logic push;
  logic pop;
  logic full;
  logic wr_en;

  // FIFO storage and bookkeeping
  logic signed [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [OW-1:0]     occ;

  // Form the group sum, divide it by DECIM and clip it to the 8-bit range
  always_comb begin
    sum     = acc + {{3{filter_in[10]}}, filter_in};
    shifted = sum >>> SHIFT;
    result  = shifted[7:0];
    clipped = 1'b0;
    if (shifted > 14'sd127) begin
      result  = 8'sd127;
      clipped = 1'b1;
    end else if (shifted < -14'sd128) begin
      result  = -8'sd128;
      clipped = 1'b1;
    end
  end

  // Decide push/pop for this cycle; a full FIFO still accepts a push when it is also popping
  always_comb begin
    last       = (cnt == CNT_MAX);
    push       = in_valid && !phase_clr && last;
    dout_valid = (occ != '0);
    full       = (occ == OCC_FULL);
    pop        = dout_valid && dout_ready;
    wr_en      = push && (!full || pop);
    dout       = dout_valid ? mem[rd_ptr] : 8'sd0;
  end

  // Accumulate samples and step the phase; phase_clr discards the partial sum
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (phase_clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // FIFO storage write; contents need no reset because occupancy gates the output
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= result;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        occ <= occ + 1'b1;
      end else if (pop && !wr_en) begin
        occ <= occ - 1'b1;
      end
    end
  end

  // Status flags: one-cycle saturation pulse and sticky drop indicator
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sat_flag <= push && clipped;
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out: directed bench for fir_decim_out with DECIM=4 and
// FIFO_DEPTH=4. Expected values are hand-computed group sums divided by 4
// (floor) and clipped to [-128, 127].
module tb_fir_decim_out;

  logic              clk;
  logic              rst;
  logic signed [10:0] filter_in;
  logic              in_valid;
  logic              phase_clr;
  logic signed [7:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              sat_flag;
  logic              overflow;

  int checks = 0;
  int passes = 0;

  fir_decim_out #(
    .DECIM      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .filter_in  (filter_in),
    .in_valid   (in_valid),
    .phase_clr  (phase_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sat_flag   (sat_flag),
    .overflow   (overflow)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let outputs settle 1 ns past the edge
  task automatic apply_stimulus(input logic signed [10:0] fi, input logic v,
                                input logic clr, input logic rdy, input logic rs);
    filter_in  = fi;
    in_valid   = v;
    phase_clr  = clr;
    dout_ready = rdy;
    rst        = rs;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with its expected value
  task automatic check_output(input string tag, input logic signed [15:0] obs,
                              input logic signed [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Directed sequence
  initial begin
    int exp_order [4];
    exp_order = '{20, 30, 40, 50};

    filter_in  = '0;
    in_valid   = 1'b0;
    phase_clr  = 1'b0;
    dout_ready = 1'b1;
    rst        = 1'b1;

    // Reset state
    apply_stimulus(0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 1, 1);
    check_output("reset_valid", dout_valid, 0);
    check_output("reset_dout", dout, 0);
    check_output("reset_sat", sat_flag, 0);
    check_output("reset_ovf", overflow, 0);

    // 1,2,3,4 -> 10/4 = 2
    $display("[TB] basic positive and negative groups");
    apply_stimulus(1, 1, 0, 1, 0);
    apply_stimulus(2, 1, 0, 1, 0);
    apply_stimulus(3, 1, 0, 1, 0);
    check_output("pos_no_early_push", dout_valid, 0);
    apply_stimulus(4, 1, 0, 1, 0);
    check_output("pos_valid", dout_valid, 1);
    check_output("pos_dout", dout, 2);
    check_output("pos_sat", sat_flag, 0);

    // -1,-2,-3,-4 -> floor(-10/4) = -3
    apply_stimulus(-1, 1, 0, 1, 0);
    check_output("pop_empties", dout_valid, 0);
    apply_stimulus(-2, 1, 0, 1, 0);
    apply_stimulus(-3, 1, 0, 1, 0);
    apply_stimulus(-4, 1, 0, 1, 0);
    check_output("neg_dout", dout, -3);
    check_output("neg_sat", sat_flag, 0);

    // 1023 x4 -> 1023 clipped to 127
    $display("[TB] saturation");
    for (int i = 0; i < 4; i++) apply_stimulus(1023, 1, 0, 1, 0);
    check_output("satpos_dout", dout, 127);
    check_output("satpos_flag", sat_flag, 1);

    // -1024 x4 -> -1024 clipped to -128; flag is a one-cycle pulse
    apply_stimulus(-1024, 1, 0, 1, 0);
    check_output("sat_pulse_ends", sat_flag, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(-1024, 1, 0, 1, 0);
    check_output("satneg_dout", dout, -128);
    check_output("satneg_flag", sat_flag, 1);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("satneg_drained", dout_valid, 0);

    // Five groups of 100 with no consumer: four stored, fifth dropped
    $display("[TB] overflow");
    for (int i = 0; i < 16; i++) apply_stimulus(100, 1, 0, 0, 0);
    check_output("fill_occ", dut.occ, 4);
    check_output("fill_no_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(100, 1, 0, 0, 0);
    check_output("drop_ovf", overflow, 1);
    check_output("drop_occ", dut.occ, 4);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("stall_dout_stable", dout, 100);
    for (int i = 0; i < 4; i++) begin
      check_output("drain_valid", dout_valid, 1);
      check_output("drain_dout", dout, 100);
      apply_stimulus(0, 0, 0, 1, 0);
    end
    check_output("drain_empty", dout_valid, 0);
    check_output("ovf_sticky", overflow, 1);

    // Reset clears the sticky overflow
    apply_stimulus(0, 0, 0, 1, 1);
    check_output("rst_clears_ovf", overflow, 0);

    // Full FIFO with push and pop in the same cycle
    $display("[TB] full push with pop");
    for (int i = 0; i < 4; i++) apply_stimulus(10, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(20, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(30, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(40, 1, 0, 0, 0);
    check_output("full_head", dout, 10);
    for (int i = 0; i < 3; i++) apply_stimulus(50, 1, 0, 0, 0);
    apply_stimulus(50, 1, 0, 1, 0);
    check_output("pushpop_occ", dut.occ, 4);
    check_output("pushpop_no_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check_output("order_dout", dout, exp_order[i]);
      apply_stimulus(0, 0, 0, 1, 0);
    end
    check_output("order_empty", dout_valid, 0);

    // Reset mid-accumulation discards the partial sum
    $display("[TB] reset mid-group");
    apply_stimulus(50, 1, 0, 1, 0);
    apply_stimulus(50, 1, 0, 1, 0);
    apply_stimulus(0, 0, 0, 1, 1);
    check_output("midrst_valid", dout_valid, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(8, 1, 0, 1, 0);
    check_output("midrst_dout", dout, 8);
    check_output("midrst_valid2", dout_valid, 1);
    check_output("midrst_ovf", overflow, 0);
    check_output("midrst_sat", sat_flag, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("midrst_single", dout_valid, 0);

    // phase_clr with in_valid discards the group; gaps do not matter
    $display("[TB] phase clear");
    for (int i = 0; i < 3; i++) apply_stimulus(40, 1, 0, 1, 0);
    apply_stimulus(40, 1, 1, 1, 0);
    check_output("clr_no_push", dout_valid, 0);
    apply_stimulus(4, 1, 0, 1, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(4, 1, 0, 1, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(4, 1, 0, 1, 0);
    check_output("gap_no_push", dout_valid, 0);
    apply_stimulus(4, 1, 0, 1, 0);
    check_output("clr_valid", dout_valid, 1);
    check_output("clr_dout", dout, 4);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("clr_single", dout_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fir_decim_out.md
FIR_DECIM_OUT -- requirements
Module: fir_decim_out

Interface
REQ-001 Parameter DECIM, default 4, meaning decimation ratio; legal values 2, 4 and 8 only.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning output FIFO entries; legal values are powers of 2 from 2 to 16.
REQ-003 Port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, width 1: reset, synchronous and active-high.
REQ-005 Port filter_in, input, width 11, signed: FIR output sample (the filter's filter_out).
REQ-006 Port in_valid, input, width 1: filter_in is a valid sample this cycle.
REQ-007 Port phase_clr, input, width 1: restart the decimation phase and discard the partial sum.
REQ-008 Port dout, output, width 8, signed: decimated, saturated sample at the FIFO head.
REQ-009 Port dout_valid, output, width 1: dout holds a valid sample.
REQ-010 Port dout_ready, input, width 1: consumer accepts dout this cycle.
REQ-011 Port sat_flag, output, width 1: one-cycle pulse when a pushed sample was saturated.
REQ-012 Port overflow, output, width 1: sticky flag meaning a decimated sample was dropped because the FIFO was full.

Function
REQ-013 The block SHALL hold a 14-bit signed accumulator acc and a phase counter cnt counting 0..DECIM-1.
REQ-014 On in_valid=1 with cnt<DECIM-1, the block SHALL set acc to acc+filter_in (sign-extended) and increment cnt.
REQ-015 On in_valid=1 with cnt=DECIM-1, the block SHALL form sum=acc+filter_in, clear acc to 0 and cnt to 0, and push one result that same cycle.
REQ-016 The result SHALL be sum shifted right arithmetically by log2(DECIM), which is floor division.
REQ-017 The shifted value SHALL saturate to the range [-128, 127] to produce the 8-bit result.
REQ-018 sat_flag SHALL be 1 in the cycle after the push exactly when clipping occurred in that push, and 0 otherwise.
REQ-019 On in_valid=0, acc and cnt SHALL hold their values.
REQ-020 phase_clr=1 SHALL clear acc and cnt and take priority over in_valid that cycle; no push occurs.
REQ-021 The FIFO SHALL be first-in first-out with registered storage, read/write pointers that wrap at FIFO_DEPTH, and an occupancy count from 0 to FIFO_DEPTH.
REQ-022 A pop SHALL occur when dout_valid=1 and dout_ready=1.
REQ-023 dout_valid SHALL equal 1 exactly when occupancy>0.
REQ-024 dout SHALL show the head entry when the FIFO is non-empty and 0 when it is empty.
REQ-025 Latency SHALL be one cycle: a push into an empty FIFO at edge N gives dout_valid=1 with that data after edge N.
REQ-026 There SHALL be no combinational path from filter_in to dout.
REQ-027 A push while full and not popping SHALL drop the new result, leave the FIFO unchanged and set overflow=1.
REQ-028 Push and pop in the same cycle SHALL both take effect, even when the FIFO is full, leaving occupancy unchanged.
REQ-029 A pop when empty SHALL be impossible, since dout_valid=0; dout_ready is ignored when empty.
REQ-030 overflow SHALL clear only on rst.
REQ-031 dout SHALL remain stable while dout_valid=1 and dout_ready=0.

Reset
REQ-032 While rst=1 at a rising clk edge, acc, cnt, pointers and occupancy SHALL go to 0, and dout, dout_valid, sat_flag and overflow SHALL go to 0.
REQ-033 rst SHALL override phase_clr, in_valid and dout_ready.
REQ-034 Reset asserted mid-accumulation SHALL discard the partial sum and all FIFO contents.

Verification
REQ-035 The bench SHALL cover, with DECIM=4 and dout_ready=1: filter_in 1,2,3,4 -> dout=2; then -1,-2,-3,-4 -> dout=-3; sat_flag=0 for both.
REQ-036 The bench SHALL cover: filter_in 1023 x4 -> dout=127 with sat_flag pulse; then -1024 x4 -> dout=-128 with sat_flag pulse.
REQ-037 The bench SHALL cover: dout_ready=0 and 5 groups of 100 x4 -> 4 entries stored, overflow=1, 5th dropped; then dout_ready=1 -> exactly four 100s, after which dout_valid=0.
REQ-038 The bench SHALL cover: FIFO full and a push coinciding with dout_ready=1 -> occupancy stays at FIFO_DEPTH, overflow stays 0, and order is preserved.
REQ-039 The bench SHALL cover: 2 samples of 50, then rst for 1 cycle, then 8 x4 -> single output dout=8, with overflow and sat_flag both 0.
REQ-040 The bench SHALL cover: 3 samples of 40, then phase_clr together with in_valid, then 4,4,4,4 -> single output dout=4; in_valid gaps between samples do not change the result.
